// File: rtl/fir_cmem_seq_if.sv
// Valid/ready sample stream used on both sides of the FIR coefficient-memory sequencer.
interface fir_cmem_seq_if #(
    parameter int DW = 16
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_cmem_seq.sv
// 64-tap FIR sequencer: buffers samples, walks the coefficient memory, returns rounded/saturated Q15 output.
// Optional macro FIR_SYM_EN: symmetric-coefficient pre-add mode, half the MAC cycles, bit-identical results.
module fir_cmem_seq #(
    parameter int NTAP   = 64,
    parameter int DW     = 16,
    parameter int ACCW   = 38,
    parameter int OSHIFT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_cmem_seq_if.slave        src,
    fir_cmem_seq_if.master       dst,
    output logic [5:0]           cmem_a,
    input  logic [DW-1:0]        cmem_q,
    output logic                 busy
);
    localparam int AW = $clog2(NTAP);
`ifdef FIR_SYM_EN
    localparam int NMAC = NTAP / 2;
    localparam int PW   = 2 * DW + 1;
`else
    localparam int NMAC = NTAP;
    localparam int PW   = 2 * DW;
`endif
    localparam logic [AW-1:0]          KLAST = AW'(NMAC - 1);
    localparam logic signed [ACCW-1:0] SMAX  = ACCW'((1 << (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SMIN  = -SMAX - ACCW'(1);
    localparam logic signed [ACCW-1:0] RHALF = ACCW'(1 << (OSHIFT - 1));

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state, state_nx;
    logic signed [ACCW-1:0] acc, acc_next, rnd, shifted;
    logic [AW-1:0]          wp, k, idx_new;
    logic [DW-1:0]          sbuf [NTAP];
    logic [DW-1:0]          s_new, out_q, sat_val;
    logic signed [PW-1:0]   prod;
    logic                   last;

    always_comb begin
        idx_new = wp - AW'(1) - k;
        s_new   = sbuf[idx_new];
        last    = (k == KLAST);
    end

`ifdef FIR_SYM_EN
    logic [AW-1:0]        idx_old;
    logic [DW-1:0]        s_old;
    logic signed [DW:0]   pre;

    // Mirror tap 63-k sits at (wp-64+k) mod 64, which is simply wp+k.
    always_comb begin
        idx_old = wp + k;
        s_old   = sbuf[idx_old];
        pre     = $signed({s_new[DW-1], s_new}) + $signed({s_old[DW-1], s_old});
        prod    = $signed(cmem_q) * pre;
    end
`else
    always_comb begin
        prod = $signed(cmem_q) * $signed(s_new);
    end
`endif

    always_comb begin
        acc_next = acc + $signed({{(ACCW - PW){prod[PW-1]}}, prod});
        rnd      = acc_next + RHALF;
        shifted  = rnd >>> OSHIFT;
        if (shifted > SMAX)
            sat_val = SMAX[DW-1:0];
        else if (shifted < SMIN)
            sat_val = SMIN[DW-1:0];
        else
            sat_val = shifted[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (src.valid) state_nx = MAC;
            MAC:     if (last) state_nx = OUT;
            OUT:     if (dst.ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        src.ready = (state == IDLE);
        dst.valid = (state == OUT);
        dst.data  = out_q;
        busy      = (state != IDLE);
        cmem_a    = (state == MAC) ? 6'(k) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            wp    <= '0;
            k     <= '0;
            out_q <= '0;
            for (int unsigned i = 0; i < NTAP; i++)
                sbuf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (src.valid) begin
                        sbuf[wp] <= src.data;
                        wp       <= wp + AW'(1);
                        acc      <= '0;
                        k        <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + AW'(1);
                    // Output is latched from the final sum so it is valid on OUT entry.
                    if (last)
                        out_q <= sat_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_cmem_seq.sv
// Directed self-checking bench for fir_cmem_seq with a behavioural ROM and a shift-register FIR model.
module tb_fir_cmem_seq;
`ifdef FIR_SYM_EN
    localparam int NMAC = 32;
`else
    localparam int NMAC = 64;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fir_cmem_seq_if #(.DW(16)) src_if ();
    fir_cmem_seq_if #(.DW(16)) dst_if ();

    logic [5:0]         cmem_a;
    logic [15:0]        cmem_q;
    logic               busy;
    logic signed [15:0] coef [64];

    always_comb cmem_q = coef[cmem_a];

    fir_cmem_seq #(.NTAP(64), .DW(16), .ACCW(38), .OSHIFT(15)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .src    (src_if),
        .dst    (dst_if),
        .cmem_a (cmem_a),
        .cmem_q (cmem_q),
        .busy   (busy)
    );

    int          tests = 0;
    int          fails = 0;
    int          hist [64];
    logic [15:0] expq [$];
    logic [15:0] last_out;

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) hist[i] = 0;
        expq.delete();
    endtask

    task automatic model_push(input logic [15:0] x);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 63; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'($signed(x));
        for (int i = 0; i < 64; i++) acc += longint'(coef[i]) * longint'(hist[i]);
        r = (acc + 16384) >>> 15;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        expq.push_back(r[15:0]);
    endtask

    task automatic send(input logic [15:0] x);
        int n;
        n = 0;
        while (src_if.ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("in_ready_wait", {31'd0, src_if.ready}, 32'd1);
        src_if.valid = 1'b1;
        src_if.data  = x;
        @(posedge clk); #1;
        src_if.valid = 1'b0;
        model_push(x);
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (dst_if.valid !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check({tag, "_out_wait"}, {31'd0, dst_if.valid}, 32'd1);
    endtask

    task automatic recv(input string tag, input int gap);
        logic [15:0] exp;
        wait_out(tag);
        repeat (gap) begin
            @(posedge clk); #1;
        end
        exp = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        last_out = dst_if.data;
        check(tag, {16'd0, dst_if.data}, {16'd0, exp});
        dst_if.ready = 1'b1;
        @(posedge clk); #1;
        dst_if.ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, dst_if.valid}, 32'd0);
    endtask

    task automatic impulse(input string tag);
        for (int i = 0; i < 64; i++) begin
            send((i == 0) ? 16'h7FFF : 16'h0000);
            recv(tag, 0);
            if (i == 0)  check({tag, "_y0"},  {16'd0, last_out}, 32'h0000FFFF);
            if (i == 31) check({tag, "_y31"}, {16'd0, last_out}, 32'h00002500);
            if (i == 32) check({tag, "_y32"}, {16'd0, last_out}, 32'h00002500);
        end
    endtask

    initial begin
        int n;
        logic [15:0] hold_exp;

        // symmetric taps: c[0]=-1 and c[31]=0x2500 are the hand-checked impulse points
        for (int k = 0; k < 32; k++) begin
            if (k == 0)       coef[k] = -16'sd1;
            else if (k == 31) coef[k] = 16'sh2500;
            else              coef[k] = 16'(((k * 2731) % 6001) - 3000);
            coef[63-k] = coef[k];
        end
        model_reset();
        rst_n        = 1'b0;
        src_if.valid = 1'b0;
        src_if.data  = '0;
        dst_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, src_if.ready}, 32'd1);
        check("rst_out_valid", {31'd0, dst_if.valid}, 32'd0);
        check("rst_out_data",  {16'd0, dst_if.data},  32'd0);
        check("rst_cmem_a",    {26'd0, cmem_a},       32'd0);
        check("rst_busy",      {31'd0, busy},         32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        impulse("imp1");

        // latency and handshake on a single sample
        src_if.valid = 1'b1;
        src_if.data  = 16'h4000;
        @(posedge clk); #1;
        src_if.valid = 1'b0;
        model_push(16'h4000);
        check("lat_in_ready_c1", {31'd0, src_if.ready}, 32'd0);
        check("lat_busy_c1",     {31'd0, busy},         32'd1);
        n = 1;
        while (dst_if.valid !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, NMAC + 1);
        check("lat_in_ready_out", {31'd0, src_if.ready}, 32'd0);
        recv("lat_data", 0);
        check("lat_in_ready_after", {31'd0, src_if.ready}, 32'd1);
        check("lat_busy_after",     {31'd0, busy},         32'd0);

        // backpressure with 0x1234 waiting
        send(16'h5A5A);
        src_if.valid = 1'b1;
        src_if.data  = 16'h1234;
        @(posedge clk); #1;
        check("bp_in_ready_mac", {31'd0, src_if.ready}, 32'd0);
        wait_out("bp");
        hold_exp = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_data",     {16'd0, dst_if.data},  {16'd0, hold_exp});
            check("bp_in_ready", {31'd0, src_if.ready}, 32'd0);
        end
        check("bp_valid_held", {31'd0, dst_if.valid}, 32'd1);
        dst_if.ready = 1'b1;
        @(posedge clk); #1;
        dst_if.ready = 1'b0;
        check("bp_hs_valid", {31'd0, dst_if.valid}, 32'd0);
        check("bp_hs_busy",  {31'd0, busy},         32'd0);
        @(posedge clk); #1;
        src_if.valid = 1'b0;
        model_push(16'h1234);
        check("bp_accept_busy", {31'd0, busy}, 32'd1);
        recv("bp_next", 0);
        repeat (NMAC + 10) @(posedge clk);
        #1;
        check("bp_no_dup_valid", {31'd0, dst_if.valid}, 32'd0);
        check("bp_no_dup_ready", {31'd0, src_if.ready}, 32'd1);

        // saturation: samples sign-matched to coefficients, then negated
        for (int i = 0; i < 64; i++) begin
            send((coef[i] < 0) ? 16'h8000 : 16'h7FFF);
            recv("sat_pos", 0);
        end
        check("sat_pos_hand", {16'd0, last_out}, 32'h00007FFF);
        for (int i = 0; i < 64; i++) begin
            send((coef[i] < 0) ? 16'h7FFF : 16'h8000);
            recv("sat_neg", 0);
        end
        check("sat_neg_hand", {16'd0, last_out}, 32'h00008000);

        // reset in the middle of a MAC pass
        send(16'h7FFF);
        n = 0;
        while (cmem_a !== 6'd20 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_tap20", {26'd0, cmem_a}, 32'd20);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, dst_if.valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, src_if.ready}, 32'd1);
        check("midrst_busy",      {31'd0, busy},         32'd0);
        check("midrst_cmem_a",    {26'd0, cmem_a},       32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        impulse("imp2");

        // random stress across two pointer wraps
        for (int i = 0; i < 130; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(16'($urandom));
            recv("stress", int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
